// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared I/O definitions for the keypad peripheral: register offsets,
//   scanner FSM state encoding and a helper that turns an active-low
//   one-of-four (or several-of-four) pattern into a bit index.
package keypad_scanner_pkg;

   localparam logic [2:0] KEY_ADDR      = 3'b000;
   localparam logic [2:0] KEY_STAT_ADDR = 3'b010;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2
   } kp_state_t;

   // Index of the lowest zero bit; the lowest index wins when several
   // bits are low. An all-ones pattern returns 0 (never used that way).
   function automatic logic [1:0] low_index(input logic [3:0] pat);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!pat[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
//   Down-counter that reloads to DIV after reaching zero and flags the
//   cycle in which it is zero. Tick period is DIV+1 clocks.
// Ports:
//   clock  in  system clock (rising edge)
//   reset  in  synchronous, active-low reset (counter loads DIV)
//   tick   out one-cycle strobe, high while the counter is zero
module scan_tick_gen #(
   parameter logic [15:0] DIV = 16'h0800
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   logic [15:0] count;

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= DIV;
      end else if (count == 16'd0) begin
         count <= DIV;
      end else begin
         count <= count - 16'd1;
      end
   end

   assign tick = (count == 16'd0);

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   4x4 matrix keypad peripheral on the CPU I/O bus. Drives one column low
//   at a time, debounces a press over several scan ticks, latches the key
//   code and exposes key/status registers to CPU reads.
// Ports:
//   clock          in   system clock (rising edge)
//   reset          in   synchronous, active-low reset
//   Select         in   chip select from the I/O decoder (gates reads only)
//   Read_enable    in   CPU read strobe
//   Address [2:0]  in   register offset (KEY_ADDR / KEY_STAT_ADDR)
//   Read_data_out  out  combinational read data, zero unless selected+read
//   Column [3:0]   out  active-low column drive
//   Row [3:0]      in   active-low row sense (pulled up externally)
//   state          out  scanner FSM state, for observation only
//
// Bus handshake: a read is the cycle where Select and Read_enable are both
// high; data is valid in that same cycle, there is no wait state, and a
// key-code read clears valid/overrun at the following rising edge.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV       = 16'h0800,
   parameter int          DEBOUNCE_SCANS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Select,
   input  logic        Read_enable,
   input  logic [2:0]  Address,
   output logic [15:0] Read_data_out,
   output logic [3:0]  Column,
   input  logic [3:0]  Row,
   output kp_state_t   state
);

   localparam int             CW    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0]  DEB_N = CW'(DEBOUNCE_SCANS);

   logic          tick;
   logic [3:0]    row_pat;
   logic [CW-1:0] deb_cnt;
   logic [CW-1:0] rel_cnt;
   logic [3:0]    key;
   logic          valid;
   logic          overrun;
   logic          key_read;
   logic          capture;
   logic [3:0]    code;

   scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   assign key_read = Select && Read_enable && (Address == KEY_ADDR);

   // Final matching sample of a debounce run: this edge latches the key.
   assign capture = tick && (state == DEBOUNCE) && (Row == row_pat) &&
                    (deb_cnt == DEB_N - CW'(1));

   // The column is held from first detection, so it still names the key.
   assign code = {low_index(row_pat), low_index(Column)};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= SCAN;
         Column  <= 4'b1110;
         row_pat <= 4'hF;
         deb_cnt <= '0;
         rel_cnt <= '0;
      end else if (tick) begin
         case (state)
            SCAN: begin
               if (Row == 4'hF) begin
                  Column <= {Column[2:0], Column[3]};
               end else begin
                  row_pat <= Row;
                  deb_cnt <= CW'(1);
                  state   <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (Row == row_pat) begin
                  if (deb_cnt == DEB_N - CW'(1)) begin
                     deb_cnt <= '0;
                     rel_cnt <= '0;
                     state   <= HOLD;
                  end else begin
                     deb_cnt <= deb_cnt + CW'(1);
                  end
               end else begin
                  deb_cnt <= '0;
                  Column  <= {Column[2:0], Column[3]};
                  state   <= SCAN;
               end
            end
            HOLD: begin
               if (Row == 4'hF) begin
                  if (rel_cnt == DEB_N - CW'(1)) begin
                     rel_cnt <= '0;
                     Column  <= {Column[2:0], Column[3]};
                     state   <= SCAN;
                  end else begin
                     rel_cnt <= rel_cnt + CW'(1);
                  end
               end else begin
                  rel_cnt <= '0;
               end
            end
            default: begin
               state  <= SCAN;
               Column <= 4'b1110;
            end
         endcase
      end
   end

   // Capture takes priority over the clear from a same-edge key read.
   // overrun only becomes set when an earlier key is still unread.
   always_ff @(posedge clock) begin
      if (!reset) begin
         key     <= 4'h0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else if (capture) begin
         key     <= code;
         valid   <= 1'b1;
         overrun <= overrun | valid;
      end else if (key_read) begin
         valid   <= 1'b0;
         overrun <= 1'b0;
      end
   end

   always_comb begin
      Read_data_out = 16'h0000;
      if (Select && Read_enable) begin
         case (Address)
            KEY_ADDR:      Read_data_out = {12'h000, key};
            KEY_STAT_ADDR: Read_data_out = {14'b0, overrun, valid};
            default:       Read_data_out = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_DIV=3, DEBOUNCE_SCANS=4. A keypad
//   model pulls rows low for pressed keys on the driven column; directed
//   cases cover reset, press/read, bounce, overrun, same-edge capture and
//   reset during hold, then randomised presses are checked against a
//   key/valid/overrun model updated once per press.
module tb_keypad_scanner;
   import keypad_scanner_pkg::*;

   localparam logic [15:0] DIV = 16'd3;
   localparam int          DEB = 4;
   localparam int          TP  = 4;  // clocks per scan tick (DIV+1)

   logic        clock;
   logic        reset;
   logic        Select;
   logic        Read_enable;
   logic [2:0]  Address;
   logic [15:0] Read_data_out;
   logic [3:0]  Column;
   logic [3:0]  Row;
   kp_state_t   dbg_state;

   logic [15:0] pressed;
   logic        force_en;
   logic [3:0]  force_row;
   logic [3:0]  model_rows;

   int n_checks;
   int n_fail;
   int edge_cnt;

   logic [3:0] exp_key;
   logic       exp_valid;
   logic       exp_overrun;

   keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clock         (clock),
      .reset         (reset),
      .Select        (Select),
      .Read_enable   (Read_enable),
      .Address       (Address),
      .Read_data_out (Read_data_out),
      .Column        (Column),
      .Row           (Row),
      .state         (dbg_state)
   );

   // clock / reset block
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // keypad matrix: a pressed key at (r,c) pulls row r low while column c is low
   always_comb begin
      model_rows = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (!Column[c]) begin
            for (int r = 0; r < 4; r++) begin
               if (pressed[r*4 + c]) model_rows[r] = 1'b0;
            end
         end
      end
   end

   assign Row = force_en ? force_row : model_rows;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver tasks; all start and end just after a falling edge
   task automatic advance(input int n);
      repeat (n) @(negedge clock);
      edge_cnt += n;
   endtask

   task automatic goto_edge(input int e);
      if (e > edge_cnt) advance(e - edge_cnt);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      edge_cnt = 0;
   endtask

   task automatic peek(input logic sel, input logic [2:0] addr, output logic [15:0] d);
      Select      = sel;
      Read_enable = 1'b1;
      Address     = addr;
      #1;
      d = Read_data_out;
      Select      = 1'b0;
      Read_enable = 1'b0;
   endtask

   // key-code read held across one rising edge so its clear side effect lands
   task automatic read_key(output logic [15:0] d);
      Select      = 1'b1;
      Read_enable = 1'b1;
      Address     = KEY_ADDR;
      #1;
      d = Read_data_out;
      @(negedge clock);
      edge_cnt++;
      Select      = 1'b0;
      Read_enable = 1'b0;
   endtask

   function automatic int tick_edge(input int t);
      return t * TP;
   endfunction

   logic [15:0] d;
   int          col;
   logic [3:0]  mask;
   int          low_r;

   initial begin
      n_checks = 0; n_fail = 0; edge_cnt = 0;
      reset = 1'b0; Select = 1'b0; Read_enable = 1'b0; Address = 3'b000;
      pressed = 16'h0000; force_en = 1'b0; force_row = 4'hF;
      @(negedge clock);

      // ---- reset ----
      do_reset();
      check("rst_column", {12'h0, Column}, 16'h000E);
      peek(1'b1, KEY_STAT_ADDR, d); check("rst_status", d, 16'h0000);
      peek(1'b1, KEY_ADDR, d);      check("rst_key", d, 16'h0000);
      goto_edge(tick_edge(1) - 1);
      check("rst_col_pre_tick", {12'h0, Column}, 16'h000E);
      goto_edge(tick_edge(1));
      check("rst_col_after_tick", {12'h0, Column}, 16'h000D);

      // ---- single press: row 2, column 1 -> key 9 ----
      do_reset();
      pressed[2*4 + 1] = 1'b1;
      // column 1 is first sampled at tick 2; capture DEB-1 ticks later
      goto_edge(tick_edge(2 + DEB - 1) - 1);
      peek(1'b1, KEY_STAT_ADDR, d); check("press_status_pre", d, 16'h0000);
      goto_edge(tick_edge(2 + DEB - 1));
      peek(1'b1, KEY_STAT_ADDR, d); check("press_status", d, 16'h0001);
      peek(1'b0, KEY_ADDR, d);      check("press_nosel", d, 16'h0000);
      peek(1'b1, 3'b001, d);        check("press_bad_addr", d, 16'h0000);
      read_key(d);                  check("press_key", d, 16'h0009);
      peek(1'b1, KEY_STAT_ADDR, d); check("press_status_clr", d, 16'h0000);
      pressed = 16'h0000;
      advance(TP * 8);

      // ---- bounce reject ----
      do_reset();
      force_en = 1'b1; force_row = 4'b1110;
      goto_edge(tick_edge(2));
      check("bounce_col_held", {12'h0, Column}, 16'h000E);
      force_row = 4'hF;
      goto_edge(tick_edge(3));
      check("bounce_state", {14'b0, dbg_state}, {14'b0, SCAN});
      check("bounce_col_adv", {12'h0, Column}, 16'h000D);
      peek(1'b1, KEY_STAT_ADDR, d); check("bounce_status", d, 16'h0000);
      force_en = 1'b0;

      // ---- overrun: key 0 then key 15 with no read between ----
      do_reset();
      pressed[0] = 1'b1;
      goto_edge(tick_edge(1 + DEB - 1));
      peek(1'b1, KEY_STAT_ADDR, d); check("ovr_first", d, 16'h0001);
      pressed = 16'h0000;
      advance(TP * 6);
      pressed[15] = 1'b1;
      advance(TP * 12);
      peek(1'b1, KEY_STAT_ADDR, d); check("ovr_status", d, 16'h0003);
      read_key(d);                  check("ovr_key", d, 16'h000F);
      peek(1'b1, KEY_STAT_ADDR, d); check("ovr_status_clr", d, 16'h0000);
      pressed = 16'h0000;
      advance(TP * 8);

      // ---- same-edge capture and key read: key 5 ----
      do_reset();
      pressed[1*4 + 1] = 1'b1;
      goto_edge(tick_edge(2 + DEB - 1) - 1);
      read_key(d);                  check("same_read_old", d, 16'h0000);
      peek(1'b1, KEY_STAT_ADDR, d); check("same_status", d, 16'h0001);
      peek(1'b1, KEY_ADDR, d);      check("same_key", d, 16'h0005);
      pressed = 16'h0000;
      advance(TP * 8);

      // ---- reset during hold with key 9 still down ----
      do_reset();
      pressed[2*4 + 1] = 1'b1;
      goto_edge(tick_edge(2 + DEB - 1) + 6);
      peek(1'b1, KEY_STAT_ADDR, d); check("hold_status", d, 16'h0001);
      do_reset();
      peek(1'b1, KEY_STAT_ADDR, d); check("hold_rst_status", d, 16'h0000);
      peek(1'b1, KEY_ADDR, d);      check("hold_rst_key", d, 16'h0000);
      check("hold_rst_column", {12'h0, Column}, 16'h000E);
      goto_edge(tick_edge(2 + DEB - 1) - 1);
      peek(1'b1, KEY_STAT_ADDR, d); check("hold_redetect_pre", d, 16'h0000);
      goto_edge(tick_edge(2 + DEB - 1));
      peek(1'b1, KEY_STAT_ADDR, d); check("hold_redetect", d, 16'h0001);
      peek(1'b1, KEY_ADDR, d);      check("hold_redetect_key", d, 16'h0009);
      pressed = 16'h0000;
      advance(TP * 8);

      // ---- randomised presses against the register model ----
      read_key(d);
      exp_key = 4'h9; exp_valid = 1'b0; exp_overrun = 1'b0;
      for (int it = 0; it < 12; it++) begin
         col  = $urandom_range(0, 3);
         mask = 4'($urandom_range(1, 15));
         low_r = 0;
         for (int r = 3; r >= 0; r--) if (mask[r]) low_r = r;
         for (int r = 0; r < 4; r++) pressed[r*4 + col] = mask[r];
         advance(TP * 12);
         exp_overrun = exp_overrun | exp_valid;
         exp_valid   = 1'b1;
         exp_key     = 4'(low_r * 4 + col);
         peek(1'b1, KEY_STAT_ADDR, d);
         check("rand_status", d, {14'b0, exp_overrun, exp_valid});
         peek(1'b1, KEY_ADDR, d);
         check("rand_key", d, {12'h000, exp_key});
         pressed = 16'h0000;
         advance(TP * 8);
         if ($urandom_range(0, 1) == 1) begin
            read_key(d);
            check("rand_read", d, {12'h000, exp_key});
            exp_valid = 1'b0; exp_overrun = 1'b0;
            peek(1'b1, KEY_STAT_ADDR, d);
            check("rand_status_clr", d, 16'h0000);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Memory-mapped 4×4 matrix keypad input peripheral on the CPU I/O bus; the read-side counterpart of the seven-segment display output port. Scans keypad columns, debounces key presses, latches one key code, and exposes key code and status registers to CPU reads. Sits beside the display module and is selected by the I/O address decoder through `Select`.

## Interface
Parameters:
- `SCAN_DIV`, 16'h0800: clocks per scan tick; the tick period is `SCAN_DIV`+1 clocks.
- `DEBOUNCE_SCANS`, 4: consecutive identical scan-tick samples needed to accept a press or a release.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Select`  in  1  chip select from the I/O decoder.
- `Read_enable`  in  1  CPU read strobe.
- `Address`  in  3  register offset: 3'b000 = key code, 3'b010 = status.
- `Read_data_out`  out  16  read data.
- `Column`  out  4  column drive; active-low; exactly one bit is low while scanning.
- `Row`  in  4  row sense; active-low; externally pulled up.

## Operation
- Scan tick: a 16-bit down-counter reloads to `SCAN_DIV` when it reaches 0. The tick is the cycle in which the counter is 0.
- `Column` rotates 4'b1110 → 1101 → 1011 → 0111 → 1110.
- FSM states and transitions:
  - SCAN: on a tick, sample `Row`.
    - `Row` == 4'hF: advance the column.
    - Otherwise: hold the column, store the pattern, set debounce count to 1, go to DEBOUNCE.
  - DEBOUNCE: on each tick, compare `Row` with the stored pattern.
    - Equal: increment the count. When the count reaches `DEBOUNCE_SCANS`, capture the key and go to HOLD.
    - Different: return to SCAN and advance the column.
  - HOLD: the column stays held. Each tick with `Row` == 4'hF increments the release count; any other value clears it. When the release count reaches `DEBOUNCE_SCANS`, go to SCAN and advance the column.
- Key code = row_index*4 + col_index, 4 bits, where the index is the position of the low bit.
  - Several rows low at once: the lowest row index wins.
- Capture: `key` ← code and `valid` ← 1. An unread key is overwritten, and `overrun` ← 1.
- Register map:
  - 3'b000: {12'h000, key}.
  - 3'b010: {14'b0, overrun, valid}.
  - Any other offset reads 16'h0000.
- `Read_data_out` is a combinational mux of the registers. It is 16'h0000 unless `Select` and `Read_enable` are both 1.
- Read side effects:
  - A read at 3'b000 clears `valid` and `overrun` at the next clock edge.
  - A status read has no side effect.

## Timing
- Reset (`reset`=0 at an edge):
  - FSM = SCAN, `Column` = 4'b1110, counter = `SCAN_DIV`.
  - `key` = 0, `valid` = 0, `overrun` = 0, all debounce counts = 0.
  - `Read_data_out` = 0.
  - A reset mid-debounce or mid-hold drops any pending press.
- The first tick comes `SCAN_DIV`+1 clocks after reset release.
- Press latency, measured from the first tick that sees the press down: `DEBOUNCE_SCANS`−1 further ticks. `valid` is visible to a read in the cycle after the capturing edge.
- Same-edge capture and key-code read: the capture wins. `valid` stays 1 and `key` takes the new code; `overrun` is set only if `valid` was 1 before that edge.
- `Select`=0 only gates reads. Scanning continues regardless of `Select`.
- The column changes only on tick edges, so `Row` has `SCAN_DIV` clocks to settle.

## Structure
- Shared I/O package holds:
  - register offsets `KEY_ADDR` = 3'b000 and `KEY_STAT_ADDR` = 3'b010;
  - the FSM state encoding: SCAN = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2.
- One natural sub-module, `scan_tick_gen`: a parameterised down-counter that emits the one-cycle tick. Display refresh can reuse it.
- Everything else is flat in `keypad_scanner`.

## Test plan
(Bench uses `SCAN_DIV`=3 and `DEBOUNCE_SCANS`=4.)
- Reset:
  - Stimulus: hold `reset`=0 for 3 clocks, then release.
  - Required: `Column`=4'b1110, status read = 16'h0000, and `Column`=4'b1101 after the first tick.
- Single press and read:
  - Stimulus: row 2 held low while column 1 is driven.
  - Required: after 4 matching ticks, status reads 16'h0001 and key reads 16'h0009. The key read returns status to 16'h0000.
- Bounce reject:
  - Stimulus: `Row` = 4'b1110 for 2 ticks, then 4'hF.
  - Required: FSM returns to SCAN, `valid` stays 0, and the column advances.
- Overrun:
  - Stimulus: press key 0 and release it without a read, then press key 15.
  - Required: status reads 16'h0003 and key reads 16'h000F.
- Same-edge capture and read:
  - Stimulus: a key-code read in the same cycle as the capture of key 5, with `valid` previously 0.
  - Required: the next status read is 16'h0001 and `key`=5.
- Reset mid-hold:
  - Stimulus: `reset`=0 during HOLD with a key still pressed.
  - Required: all registers read 0 and `Column`=4'b1110. The still-held key is re-detected only after it completes the full debounce sequence again.
